// File: rtl/alu_writeback_if.sv
// ALU writeback bus: producer-side entry fields, consumer-side writeback fields, arch flags.
// Ports: in_* entry + in_valid/in_ready, out_* entry + out_valid/out_ready, flags_q, ovf_trap.
// slave modport is the writeback stage; master modport is whoever drives/consumes it.
interface alu_writeback_if #(
  parameter int RD_W = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_result;
  logic [3:0]      in_flags;
  logic            in_flags_en;
  logic [RD_W-1:0] in_rd;
  logic            in_we;
  logic            in_branch;
  logic [2:0]      in_cond;

  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_data;
  logic [RD_W-1:0] out_rd;
  logic            out_we;
  logic            out_taken;

  logic [3:0]      flags_q;
  logic            ovf_trap;

  modport slave (
    input  in_valid, in_result, in_flags, in_flags_en, in_rd, in_we, in_branch, in_cond,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_rd, out_we, out_taken,
    output flags_q, ovf_trap
  );

  modport master (
    output in_valid, in_result, in_flags, in_flags_en, in_rd, in_we, in_branch, in_cond,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_rd, out_we, out_taken,
    input  flags_q, ovf_trap
  );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: 2-entry in-order skid buffer, flag register, branch condition evaluation.
// Latency: entry accepted at edge t is on out_* after edge t; 1 entry/cycle sustained.
// Backpressure: in_ready is registered, drops only when both slots are full (TWO).
// Ports: clk, rst_n (async, active-low), io_bus (alu_writeback_if.slave: in_*, out_*, flags_q, ovf_trap).
// Option: define ALU_OVF_TRAP_EN to pulse ovf_trap and squash out_we for entries that set v.
module alu_writeback #(
  parameter int RD_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_writeback_if.slave io_bus
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef struct packed {
    logic [15:0]     data;
    logic [RD_W-1:0] rd;
    logic            we;
    logic            taken;
  } ent_t;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_in_rdy;
  logic [3:0] r_flags;
  ent_t       r_head;
  ent_t       r_tail;
  ent_t       w_new;
  logic       w_accept;
  logic       w_drain;
  logic       w_out_vld;
  logic       w_head_ld;
  logic       w_head_from_tail;
  logic       w_tail_ld;

  // Flags are {z,c,n,v}.
  function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    {z, c, n, v} = f;
    case (cond)
      3'd0:    cond_met = 1'b1;
      3'd1:    cond_met = z;
      3'd2:    cond_met = ~z;
      3'd3:    cond_met = c;
      3'd4:    cond_met = ~c;
      3'd5:    cond_met = n;
      3'd6:    cond_met = n ^ v;
      default: cond_met = ~(n ^ v);
    endcase
  endfunction

  assign w_out_vld = (r_state != EMPTY);
  assign w_accept  = io_bus.in_valid & r_in_rdy;
  assign w_drain   = w_out_vld & io_bus.out_ready;

  // Branch outcome uses the flags as they stand before this entry's own update;
  // the previous entry's update has already landed in r_flags, so no hazard.
  always_comb begin
    w_new.data  = io_bus.in_result;
    w_new.rd    = io_bus.in_rd;
    w_new.we    = io_bus.in_we;
    w_new.taken = io_bus.in_branch & cond_met(io_bus.in_cond, r_flags);
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_head_ld        = 1'b0;
    w_head_from_tail = 1'b0;
    w_tail_ld        = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ONE;
          w_head_ld   = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_drain) begin
          w_head_ld = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = TWO;
          w_tail_ld   = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (w_drain) begin
          w_state_nxt      = ONE;
          w_head_ld        = 1'b1;
          w_head_from_tail = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_in_rdy <= 1'b0;
      r_flags  <= 4'd0;
      r_head   <= '0;
      r_tail   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_rdy <= (w_state_nxt != TWO);
      if (w_accept && io_bus.in_flags_en) r_flags <= io_bus.in_flags;
      if (w_head_ld) r_head <= w_head_from_tail ? r_tail : w_new;
      if (w_tail_ld) r_tail <= w_new;
    end
  end

  assign io_bus.in_ready  = r_in_rdy;
  assign io_bus.out_valid = w_out_vld;
  assign io_bus.out_data  = r_head.data;
  assign io_bus.out_rd    = r_head.rd;
  assign io_bus.out_taken = w_out_vld & r_head.taken;
  assign io_bus.flags_q   = r_flags;

`ifdef ALU_OVF_TRAP_EN
  // Trap marker travels with its entry: set when the entry itself wrote v=1.
  logic r_head_trap;
  logic r_tail_trap;
  logic w_new_trap;

  assign w_new_trap = io_bus.in_flags_en & io_bus.in_flags[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_trap <= 1'b0;
      r_tail_trap <= 1'b0;
    end else begin
      if (w_head_ld) r_head_trap <= w_head_from_tail ? r_tail_trap : w_new_trap;
      if (w_tail_ld) r_tail_trap <= w_new_trap;
    end
  end

  assign io_bus.out_we   = w_out_vld & r_head.we & ~r_head_trap;
  assign io_bus.ovf_trap = w_drain & r_head_trap;
`else
  assign io_bus.out_we   = w_out_vld & r_head.we;
  assign io_bus.ovf_trap = 1'b0;
`endif

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter RD_W, default 3, destination register index width.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  ALU entry present.
REQ-005 SHALL have port in_ready  output  1  entry accepted when in_valid && in_ready.
REQ-006 SHALL have port in_result  input  16  ALU result d.
REQ-007 SHALL have port in_flags  input  4  ALU flags, packed {z,c,n,v}, MSB first.
REQ-008 SHALL have port in_flags_en  input  1  entry updates the flag register.
REQ-009 SHALL have port in_rd / in_we  input  RD_W / 1  destination index / register write request.
REQ-010 SHALL have port in_branch / in_cond  input  1 / 3  entry is a conditional branch / condition code.
REQ-011 SHALL have port out_valid  output  1  writeback entry present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-013 SHALL have ports out_data 16, out_rd RD_W, out_we 1, out_taken 1  output  registered entry fields.
REQ-014 SHALL have port flags_q  output  4  architectural flags {z,c,n,v}.
REQ-015 SHALL have port ovf_trap  output  1  overflow trap pulse (see Configuration).

Function
REQ-016 SHALL buffer entries in a 2-entry in-order skid buffer, states EMPTY, ONE, TWO.
REQ-017 SHALL transition: accept-only EMPTY->ONE, ONE->TWO; drain-only TWO->ONE, ONE->EMPTY; accept+drain same cycle holds state.
REQ-018 SHALL drive in_ready from a register: 1 in EMPTY/ONE, 0 in TWO; in_valid ignored while in_ready=0.
REQ-019 SHALL present an entry accepted at edge t on out_* after edge t (1-cycle latency), sustaining 1 entry/cycle with out_ready held 1.
REQ-020 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drive out_* from the head entry only; out_valid=0 implies out_we=0, out_taken=0.
REQ-022 SHALL on acceptance with in_flags_en=1 load flags_q<=in_flags; flags_en=0 leaves flags_q unchanged.
REQ-023 SHALL evaluate out_taken at acceptance against flags_q before this entry's own update: 0 AL=1, 1 EQ=z, 2 NE=!z, 3 CS=c, 4 CC=!c, 5 MI=n, 6 LT=n^v, 7 GE=!(n^v); out_taken=0 when in_branch=0.
REQ-024 SHALL give back-to-back entries no flag hazard: entry accepted at t+1 sees flags written by entry accepted at t.
REQ-025 SHALL store in_rd, in_we, in_result unmodified; no arithmetic on data.

Reset
REQ-026 SHALL on rst_n=0 immediately force state EMPTY, flags_q=0, out_valid=0, out_data=0, out_rd=0, out_we=0, out_taken=0, ovf_trap=0, in_ready=0.
REQ-027 SHALL raise in_ready=1 at first rising clk after rst_n deasserts; buffered entries dropped on reset mid-operation.

Configuration
REQ-028 SHALL, when ALU_OVF_TRAP_EN is defined, pulse ovf_trap 1 cycle on output handshake of an entry accepted with in_flags_en=1 and v=1, and force that entry's out_we=0.
REQ-029 SHALL, when ALU_OVF_TRAP_EN is undefined, tie ovf_trap=0 and never suppress out_we.

Verification
REQ-030 SHALL cover: reset, accept {result=0x1234,rd=2,we=1}, out_ready=1 -> next cycle out_valid=1, out_data=0x1234, out_rd=2, out_we=1.
REQ-031 SHALL cover: out_ready=0, 3 entries offered -> 2 accepted, in_ready=0 in TWO; out_ready=1 -> in-order drain, no loss/duplicate.
REQ-032 SHALL cover: entry flags_en=1 flags=1000 then branch cond=1 next cycle -> out_taken=1; cond=2 -> 0.
REQ-033 SHALL cover: single entry branch cond=6 with flags_en=1 flags=0010 while flags_q=0000 -> out_taken=0, flags_q=0010 after.
REQ-034 SHALL cover: rst_n low while state TWO -> out_valid=0, flags_q=0 immediately, no clock required.
REQ-035 SHALL cover: ALU_OVF_TRAP_EN defined, entry flags_en=1 v=1 we=1 -> ovf_trap=1 for 1 cycle, out_we=0; undefined -> ovf_trap=0, out_we=1.
